mbist_march: RTL and testbench

Parametrised March C- memory BIST controller; the next generation of the team's single-pattern w0/r0 BIST. It drives the memory port (ce/we/address/write data) through all six March C- elements over every word of every bank. Read data is checked against a pipelined expected value. Each failing word is pushed into a small fault FIFO, which BIRA drains over a valid/ready handshake. It sits between the memory wrapper and the BIRA/repair-analysis block.

---
 rtl/mbist_march.sv | 148 ++++++++++++++
 tb/tb_mbist_march.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mbist_march.sv
// mbist_march: March C- memory BIST controller with pipelined read compare and a fault FIFO for BIRA.
module mbist_march #(
  parameter int DW = 8,
  parameter int ROW_W = 10,
  parameter int COL_W = 10,
  parameter int NBANK = 2,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4,
  localparam int BW = NBANK > 1 ? $clog2(NBANK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test,
  input  logic             early_term,
  input  logic             bg_sel,
  input  logic [DW-1:0]    data_r,
  output logic             ce,
  output logic             we,
  output logic [ROW_W-1:0] row_addr,
  output logic [COL_W-1:0] col_addr,
  output logic [NBANK-1:0] bank_addr,
  output logic [DW-1:0]    data_w,
  output logic             test_end,
  output logic             test_aborted,
  output logic             fault_valid,
  input  logic             fault_ready,
  output logic [ROW_W-1:0] fault_row,
  output logic [COL_W-1:0] fault_col,
  output logic [BW-1:0]    fault_bank,
  output logic [DW-1:0]    fault_mask,
  output logic [2:0]       fault_elem,
  output logic [15:0]      fault_cnt
);
  localparam logic [3:0] IDLE = 4'd0, M0 = 4'd1, M1 = 4'd2, M2 = 4'd3, M3 = 4'd4;
  localparam logic [3:0] M4 = 4'd5, M5 = 4'd6, DRAIN = 4'd7, DONE = 4'd8;
  localparam int AW = $clog2(FIFO_D);
  localparam int EW = 3 + BW + COL_W + ROW_W + DW;
  localparam logic [ROW_W-1:0] RMAX = '1;
  localparam logic [COL_W-1:0] CMAX = '1;
  localparam logic [BW-1:0] BMAX = BW'(NBANK - 1);
  logic [3:0] state, st;
  logic phase, bg, bgv, start, is_m, two, down, nd, last, rd, pbit, dbit, room, issue, adv;
  logic [ROW_W-1:0] row, row_n;
  logic [COL_W-1:0] col, col_n;
  logic [BW-1:0] bank, bank_n;
  logic [RD_LAT:0] pv;
  logic [EW-1:0] pd [0:RD_LAT];
  logic [EW-1:0] fm [0:FIFO_D-1];
  logic [DW-1:0] mask;
  logic push, pop;
  logic [AW:0] fcnt;
  logic [AW-1:0] wp, rp;
  // IDLE with test=1 issues the first M0 write in the same cycle, so st folds that case in
  always_comb begin
    start = state == IDLE && test;
    st = start ? M0 : state;
    is_m = st >= M0 && st <= M5;
    two = st >= M1 && st <= M4;
    down = st == M3 || st == M4;
    nd = st == M2 || st == M3;
    rd = st == M5 || (two && !phase);
    pbit = two && (phase ^ (st == M2 || st == M4));
    bgv = start ? bg_sel : bg;
    dbit = pbit ^ (bgv & (row[0] ^ col[0]));
    last = down ? (row == '0 && col == '0 && bank == '0) : (row == RMAX && col == CMAX && bank == BMAX);
    room = int'(fcnt) + $countones(pv) < FIFO_D;
    issue = is_m && room && (start || !early_term);
    adv = issue && !(two && !phase);
    row_n = down ? row - 1'b1 : row + 1'b1;
    col_n = (down ? row == '0 : row == RMAX) ? (down ? col - 1'b1 : col + 1'b1) : col;
    bank_n = (down ? (row == '0 && col == '0) : (row == RMAX && col == CMAX)) ? (down ? bank - 1'b1 : bank + 1'b1) : bank;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= 1'b0;
      row <= '0;
      col <= '0;
      bank <= '0;
      bg <= 1'b0;
      ce <= 1'b0;
      we <= 1'b0;
      row_addr <= '0;
      col_addr <= '0;
      bank_addr <= '0;
      data_w <= '0;
      test_aborted <= 1'b0;
      fault_cnt <= '0;
      pv <= '0;
    end else begin
      ce <= issue;
      we <= issue && !rd;
      if (issue) begin
        row_addr <= row;
        col_addr <= col;
        bank_addr <= NBANK'(1) << bank;
        data_w <= {DW{dbit}};
      end
      pv <= {pv[RD_LAT-1:0], issue && rd};
      if (start) bg <= bg_sel;
      fault_cnt <= start ? '0 : (push && ~&fault_cnt) ? fault_cnt + 16'd1 : fault_cnt;
      if (is_m && !start && early_term) begin
        state <= DRAIN;
        test_aborted <= 1'b1;
      end else if (adv && last) state <= st == M5 ? DRAIN : st + 4'd1;
      else if (start) state <= M0;
      else if (state == DRAIN && ~|pv[RD_LAT-1:0]) state <= DONE;
      else if (state == DONE && !test) state <= IDLE;
      if (state == DRAIN && early_term) test_aborted <= 1'b1;
      if (start) test_aborted <= 1'b0;
      if (adv) begin
        phase <= 1'b0;
        row <= last ? (nd ? RMAX : '0) : row_n;
        col <= last ? (nd ? CMAX : '0) : col_n;
        bank <= last ? (nd ? BMAX : '0) : bank_n;
      end else if (issue) phase <= 1'b1;
      else if (!is_m) begin
        phase <= 1'b0;
        row <= '0;
        col <= '0;
        bank <= '0;
      end
    end
  end
  // compare pipeline carries {elem, bank, col, row, expected}; FIFO entries swap expected for mask
  assign mask = data_r ^ pd[RD_LAT][DW-1:0];
  assign push = pv[RD_LAT] && |mask;
  assign fault_valid = fcnt != '0;
  assign pop = fault_valid && fault_ready;
  assign test_end = state == DONE;
  assign {fault_elem, fault_bank, fault_col, fault_row, fault_mask} = fault_valid ? fm[rp] : '0;
  always_ff @(posedge clk) begin
    pd[0] <= {3'(st - 4'd1), bank, col, row, {DW{dbit}}};
    for (int k = 1; k <= RD_LAT; k++) pd[k] <= pd[k-1];
    if (push) fm[wp] <= {pd[RD_LAT][EW-1:DW], mask};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      fcnt <= fcnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_mbist_march.sv
// tb_mbist_march: scoreboard bench for mbist_march with behavioural memories (RD_LAT 1 and 3).
module tb_mbist_march;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic test_a = 0, et_a = 0, bg_a = 0, ready_a = 1;
  logic test_b = 0, et_b = 0, bg_b = 0, ready_b = 1;
  logic [7:0] data_r_a, data_r_b, data_w_a, data_w_b, fmask_a, fmask_b;
  logic ce_a, we_a, end_a, abort_a, fv_a, ce_b, we_b, end_b, abort_b, fv_b;
  logic [1:0] row_a, col_a, bank_addr_a, frow_a, fcol_a;
  logic [1:0] row_b, col_b, bank_addr_b, frow_b, fcol_b;
  logic [0:0] fbank_a, fbank_b;
  logic [2:0] felem_a, felem_b;
  logic [15:0] fcnt_a, fcnt_b;
  mbist_march #(.DW(8), .ROW_W(2), .COL_W(2), .NBANK(2), .RD_LAT(1), .FIFO_D(4)) u_dut_a (
    .clk(clk), .rst(rst), .test(test_a), .early_term(et_a), .bg_sel(bg_a), .data_r(data_r_a),
    .ce(ce_a), .we(we_a), .row_addr(row_a), .col_addr(col_a), .bank_addr(bank_addr_a), .data_w(data_w_a),
    .test_end(end_a), .test_aborted(abort_a), .fault_valid(fv_a), .fault_ready(ready_a),
    .fault_row(frow_a), .fault_col(fcol_a), .fault_bank(fbank_a), .fault_mask(fmask_a),
    .fault_elem(felem_a), .fault_cnt(fcnt_a));
  mbist_march #(.DW(8), .ROW_W(2), .COL_W(2), .NBANK(2), .RD_LAT(3), .FIFO_D(4)) u_dut_b (
    .clk(clk), .rst(rst), .test(test_b), .early_term(et_b), .bg_sel(bg_b), .data_r(data_r_b),
    .ce(ce_b), .we(we_b), .row_addr(row_b), .col_addr(col_b), .bank_addr(bank_addr_b), .data_w(data_w_b),
    .test_end(end_b), .test_aborted(abort_b), .fault_valid(fv_b), .fault_ready(ready_b),
    .fault_row(frow_b), .fault_col(fcol_b), .fault_bank(fbank_b), .fault_mask(fmask_b),
    .fault_elem(felem_b), .fault_cnt(fcnt_b));
  // memories: word index = {bank, col, row}; stuck-at-1 bits OR'd in on read
  logic [7:0] mem_a [32], mem_b [32], sa1_a [32], sa1_b [32], rq_b [3];
  logic [4:0] ad_a, ad_b;
  assign ad_a = {bank_addr_a[1], col_a, row_a};
  assign ad_b = {bank_addr_b[1], col_b, row_b};
  assign data_r_b = rq_b[2];
  always @(posedge clk) begin
    if (ce_a && we_a) mem_a[ad_a] <= data_w_a;
    data_r_a <= mem_a[ad_a] | sa1_a[ad_a];
    if (ce_b && we_b) mem_b[ad_b] <= data_w_b;
    rq_b[0] <= mem_b[ad_b] | sa1_b[ad_b];
    rq_b[1] <= rq_b[0];
    rq_b[2] <= rq_b[1];
  end
  int checks = 0, errors = 0, nce_a = 0, nfv_a = 0;
  logic [15:0] sb_a [$], sb_b [$];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask
  function automatic logic [15:0] mk(input int e, input int idx, input logic [7:0] m);
    return {3'(e), 5'(idx), m};
  endfunction
  always @(negedge clk) begin
    if (ce_a) nce_a++;
    if (fv_a) nfv_a++;
    if (fv_a && ready_a) begin
      if (sb_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_a got=%h required=no entry", {felem_a, fbank_a, fcol_a, frow_a, fmask_a});
      end else chk("sb_a", 32'({felem_a, fbank_a, fcol_a, frow_a, fmask_a}), 32'(sb_a.pop_front()));
    end
    if (fv_b && ready_b) begin
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_b got=%h required=no entry", {felem_b, fbank_b, fcol_b, frow_b, fmask_b});
      end else chk("sb_b", 32'({felem_b, fbank_b, fcol_b, frow_b, fmask_b}), 32'(sb_b.pop_front()));
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_end(input bit b, input int budget);
    int i = 0;
    while (!(b ? end_b : end_a) && i < budget) begin
      tick(1);
      i++;
    end
    chk(b ? "test_end_b" : "test_end_a", 32'(b ? end_b : end_a), 32'd1);
  endtask
  task automatic run_a(input logic bg, input logic [15:0] cnt);
    bg_a = bg;
    test_a = 1;
    wait_end(0, 600);
    chk("fault_cnt_a", 32'(fcnt_a), 32'(cnt));
    chk("aborted_a", 32'(abort_a), 0);
    test_a = 0;
    tick(4);
    chk("sb_a_empty", sb_a.size(), 0);
  endtask
  int bp_idx [6] = '{1, 5, 10, 17, 22, 31};
  int n0, f0;
  initial begin
    for (int i = 0; i < 32; i++) begin
      sa1_a[i] = 0;
      sa1_b[i] = 0;
    end
    tick(3);
    chk("rst_ce", 32'(ce_a), 0);
    chk("rst_we", 32'(we_a), 0);
    chk("rst_addr", 32'({row_a, col_a, bank_addr_a}), 0);
    chk("rst_data_w", 32'(data_w_a), 0);
    chk("rst_flags", 32'({end_a, abort_a, fv_a}), 0);
    chk("rst_fault_cnt", 32'(fcnt_a), 0);
    rst = 0;
    tick(2);
    // fault-free run: 320 issues, no faults, first op is M0 write at address 0
    n0 = nce_a;
    f0 = nfv_a;
    test_a = 1;
    tick(1);
    chk("start_op", 32'({ce_a, we_a, row_a, col_a, bank_addr_a, data_w_a}), 32'({1'b1, 1'b1, 2'd0, 2'd0, 2'b01, 8'h00}));
    wait_end(0, 600);
    chk("issue_count", nce_a - n0, 320);
    chk("no_fault_valid", nfv_a - f0, 0);
    chk("fault_cnt_clean", 32'(fcnt_a), 0);
    chk("aborted_clean", 32'(abort_a), 0);
    test_a = 0;
    tick(1);
    chk("done_to_idle", 32'(end_a), 0);
    // stuck-at-1 bit 3 at bank1 row2 col1 (word 22)
    sa1_a[22] = 8'h08;
    for (int e = 1; e <= 5; e += 2) sb_a.push_back(mk(e, 22, 8'h08));
    run_a(0, 3);
    for (int e = 2; e <= 4; e += 2) sb_a.push_back(mk(e, 22, 8'h08));
    run_a(1, 2);
    // back-pressure: six faulty words, consumer stalled
    sa1_a[22] = 0;
    for (int k = 0; k < 6; k++) sa1_a[bp_idx[k]] = 8'h01 << k;
    for (int k = 0; k < 6; k++) sb_a.push_back(mk(1, bp_idx[k], 8'h01 << k));
    for (int k = 5; k >= 0; k--) sb_a.push_back(mk(3, bp_idx[k], 8'h01 << k));
    for (int k = 0; k < 6; k++) sb_a.push_back(mk(5, bp_idx[k], 8'h01 << k));
    ready_a = 0;
    bg_a = 0;
    test_a = 1;
    tick(350);
    n0 = nce_a;
    tick(50);
    chk("stall_no_issue", nce_a - n0, 0);
    chk("stall_fault_cnt", 32'(fcnt_a), 4);
    chk("stall_valid", 32'({fv_a, end_a}), 32'b10);
    ready_a = 1;
    wait_end(0, 800);
    chk("bp_fault_cnt", 32'(fcnt_a), 18);
    tick(6);
    chk("bp_sb_empty", sb_a.size(), 0);
    test_a = 0;
    tick(2);
    // reset mid-M2, then restart
    for (int k = 0; k < 6; k++) sa1_a[bp_idx[k]] = 0;
    sa1_a[3] = 8'h02;
    sb_a.push_back(mk(1, 3, 8'h02));
    test_a = 1;
    tick(110);
    chk("pre_rst_fault_cnt", 32'(fcnt_a), 1);
    rst = 1;
    tick(1);
    chk("midrst_mem", 32'({ce_a, we_a, row_a, col_a, bank_addr_a, data_w_a}), 0);
    chk("midrst_flags", 32'({end_a, abort_a, fv_a, fcnt_a}), 0);
    rst = 0;
    for (int e = 1; e <= 5; e += 2) sb_a.push_back(mk(e, 3, 8'h02));
    tick(1);
    chk("restart_op", 32'({ce_a, we_a, row_a, col_a, bank_addr_a}), 32'({1'b1, 1'b1, 2'd0, 2'd0, 2'b01}));
    run_a(0, 3);
    // early_term during the M3 read of word 20 (issue 182) on the RD_LAT=3 instance
    sa1_b[20] = 8'h20;
    sb_b.push_back(mk(1, 20, 8'h20));
    sb_b.push_back(mk(3, 20, 8'h20));
    test_b = 1;
    tick(183);
    chk("et_op", 32'({ce_b, we_b, row_b, col_b, bank_addr_b}), 32'({1'b1, 1'b0, 2'd0, 2'd1, 2'b10}));
    et_b = 1;
    tick(1);
    et_b = 0;
    chk("et_ce_drop", 32'(ce_b), 0);
    wait_end(1, 50);
    chk("et_aborted", 32'(abort_b), 1);
    chk("et_fault_cnt", 32'(fcnt_b), 2);
    test_b = 0;
    tick(1);
    chk("et_idle", 32'({end_b, abort_b}), 32'b01);
    tick(3);
    chk("et_sb_empty", sb_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
